// File: rtl/fb_writer.sv
// Rectangle fill engine: accepts a clipped rectangle command and streams
// row-major colour writes into a synchronous framebuffer RAM.
module fb_writer #(
    parameter int WIDTH = 8,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [$clog2(FB_W)-1:0]           cmd_x,
    input  logic [$clog2(FB_H)-1:0]           cmd_y,
    input  logic [$clog2(FB_W):0]             cmd_w,
    input  logic [$clog2(FB_H):0]             cmd_h,
    input  logic [WIDTH-1:0]                  cmd_color,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_we,
    output logic [$clog2(FB_W*FB_H)-1:0]      mem_addr,
    output logic [WIDTH-1:0]                  mem_data
);

    localparam int XW    = $clog2(FB_W);
    localparam int YW    = $clog2(FB_H);
    localparam int ADDRW = $clog2(FB_W * FB_H);
    localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(FB_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [XW:0]        ew_r;
    logic [YW:0]        eh_r;
    logic [XW:0]        col_r;
    logic [YW:0]        row_r;
    logic [ADDRW-1:0]   addr_r;
    logic [ADDRW-1:0]   row_base_r;
    logic [WIDTH-1:0]   data_r;

    logic [XW:0]        rem_x_s;
    logic [YW:0]        rem_y_s;
    logic [XW:0]        ew_s;
    logic [YW:0]        eh_s;
    logic [ADDRW-1:0]   base_s;
    logic               accept_s;
    logic               zero_s;
    logic               col_last_s;
    logic               last_s;

    // Clip the incoming rectangle against the framebuffer edges
    always_comb begin
        rem_x_s = (XW+1)'(FB_W) - {1'b0, cmd_x};
        rem_y_s = (YW+1)'(FB_H) - {1'b0, cmd_y};
        if ({1'b0, cmd_x} >= (XW+1)'(FB_W)) begin
            ew_s = (XW+1)'(0);
        end else if (cmd_w < rem_x_s) begin
            ew_s = cmd_w;
        end else begin
            ew_s = rem_x_s;
        end
        if ({1'b0, cmd_y} >= (YW+1)'(FB_H)) begin
            eh_s = (YW+1)'(0);
        end else if (cmd_h < rem_y_s) begin
            eh_s = cmd_h;
        end else begin
            eh_s = rem_y_s;
        end
    end

    assign base_s     = ADDRW'(cmd_y) * ROW_STEP + ADDRW'(cmd_x);
    assign accept_s   = cmd_valid && (state_r == S_IDLE);
    assign zero_s     = (ew_s == (XW+1)'(0)) || (eh_s == (YW+1)'(0));
    assign col_last_s = (col_r == ew_r - (XW+1)'(1));
    assign last_s     = col_last_s && (row_r == eh_r - (YW+1)'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; empty rectangles skip straight to the completion pulse
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (zero_s) begin
                        state_nx_s = S_DONE;
                    end else begin
                        state_nx_s = S_FILL;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_FILL: begin
                if (last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_FILL;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Command latch and raster walk; next-row address comes from a running row base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ew_r       <= '0;
            eh_r       <= '0;
            col_r      <= '0;
            row_r      <= '0;
            addr_r     <= '0;
            row_base_r <= '0;
            data_r     <= '0;
        end else if (accept_s) begin
            ew_r       <= ew_s;
            eh_r       <= eh_s;
            col_r      <= '0;
            row_r      <= '0;
            addr_r     <= base_s;
            row_base_r <= base_s;
            data_r     <= cmd_color;
        end else if (state_r == S_FILL) begin
            if (col_last_s) begin
                col_r      <= '0;
                row_r      <= row_r + (YW+1)'(1);
                row_base_r <= row_base_r + ROW_STEP;
                addr_r     <= row_base_r + ROW_STEP;
            end else begin
                col_r  <= col_r + (XW+1)'(1);
                addr_r <= addr_r + ADDRW'(1);
            end
        end
    end

    assign cmd_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign done      = (state_r == S_DONE);
    assign mem_we    = (state_r == S_FILL);
    assign mem_addr  = addr_r;
    assign mem_data  = data_r;

endmodule
